// File: rtl/hilo_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide controller.
package hilo_pkg;

  localparam int ITER_COUNT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    WB
  } state_t;

  // Worked at 33 bits so that -2^31 becomes +2^31 instead of wrapping back to itself.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    magnitude = (is_signed && v[31]) ? 32'(-{1'b1, v}) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/stall handshake and HI/LO write port between the pipeline and hilo_muldiv_ctrl.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             flush;
  logic             busy;
  logic             done;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;

  modport master (
    output start, op, rs_data, rt_data, flush,
    input  busy, done, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush,
    output busy, done, hi_we, lo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/hilo_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the partial remainder.
module hilo_div_step
  import hilo_pkg::*;
(
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_n,
  output logic [31:0] quo_n
);

  logic [32:0] shifted;
  logic        ge;

  assign shifted = {rem, quo[31]};
  assign ge      = (shifted >= {1'b0, divisor});
  assign rem_n   = ge ? 32'(shifted - {1'b0, divisor}) : shifted[31:0];
  assign quo_n   = {quo[30:0], ge};

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: FSM, iterative shift-add multiplier, divider and sign fix-up.
// Defining MULDIV_FAST_MUL_EN replaces the iterative multiplier with a single-cycle 64-bit multiply.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  hilo_muldiv_ctrl_if.slave bus
);

  state_t state, state_n;

  // prod holds {acc, multiplier} while multiplying and {remainder, quotient} while dividing.
  logic [63:0] prod;
  logic [31:0] mcand;
  logic [31:0] rs_q;
  logic [4:0]  cnt;
  logic        is_div_q, neg_q, neg_r, dz_q;

  logic        accept, op_is_mul, op_is_div, op_signed, last_iter;
  logic [32:0] mul_sum;
  logic [31:0] rem_n, quo_n;
  logic [63:0] fix_prod;
  logic        hi_we_n, lo_we_n;
  logic [31:0] hi_d, lo_d;

  logic             busy_q, done_q, hi_we_q, lo_we_q;
  logic [WIDTH-1:0] hi_wdata_q, lo_wdata_q;

`ifdef MULDIV_FAST_MUL_EN
  localparam state_t MUL_ENTRY = WB;
  logic [63:0] fast_prod;
  assign fast_prod = {{32{op_signed & bus.rs_data[31]}}, bus.rs_data} *
                     {{32{op_signed & bus.rt_data[31]}}, bus.rt_data};
`else
  localparam state_t MUL_ENTRY = MUL;
`endif

  assign op_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign op_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign last_iter = (cnt == 5'(ITER_COUNT - 1));
  assign mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
  assign fix_prod  = neg_q ? -prod : prod;

  hilo_div_step u_div_step (
    .rem     (prod[63:32]),
    .quo     (prod[31:0]),
    .divisor (mcand),
    .rem_n   (rem_n),
    .quo_n   (quo_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state; flush beats start and every in-flight state, WB always drains to IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_is_mul)                                     state_n = MUL_ENTRY;
          else if (op_is_div)                                state_n = DIV;
          else if (bus.op == OP_MTHI || bus.op == OP_MTLO)   state_n = WB;
        end
      end
      MUL:     if (bus.flush) state_n = IDLE; else if (last_iter)         state_n = FIX;
      DIV:     if (bus.flush) state_n = IDLE; else if (dz_q || last_iter) state_n = FIX;
      FIX:     state_n = bus.flush ? IDLE : WB;
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Write port contents for the cycle about to enter WB; data otherwise holds its last value.
  always_comb begin
    hi_we_n = 1'b0;
    lo_we_n = 1'b0;
    hi_d    = hi_wdata_q;
    lo_d    = lo_wdata_q;
    if (accept) begin
      if (bus.op == OP_MTHI) begin
        hi_we_n = 1'b1;
        hi_d    = bus.rs_data;
      end
      if (bus.op == OP_MTLO) begin
        lo_we_n = 1'b1;
        lo_d    = bus.rs_data;
      end
`ifdef MULDIV_FAST_MUL_EN
      if (op_is_mul) begin
        hi_we_n      = 1'b1;
        lo_we_n      = 1'b1;
        {hi_d, lo_d} = fast_prod;
      end
`endif
    end else if (state == FIX && !bus.flush) begin
      hi_we_n = 1'b1;
      lo_we_n = 1'b1;
      if (dz_q) begin
        hi_d = rs_q;
        lo_d = 32'hFFFF_FFFF;
      end else if (is_div_q) begin
        lo_d = neg_q ? -prod[31:0]  : prod[31:0];
        hi_d = neg_r ? -prod[63:32] : prod[63:32];
      end else begin
        {hi_d, lo_d} = fix_prod;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod     <= '0;
      mcand    <= '0;
      rs_q     <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept && (op_is_mul || op_is_div)) begin
      cnt      <= '0;
      is_div_q <= op_is_div;
      neg_q    <= op_signed & (bus.rs_data[31] ^ bus.rt_data[31]);
      neg_r    <= op_signed & bus.rs_data[31];
      dz_q     <= op_is_div && (bus.rt_data == 32'd0);
      rs_q     <= bus.rs_data;
      mcand    <= magnitude(op_is_div ? bus.rt_data : bus.rs_data, op_signed);
      prod     <= {32'd0, magnitude(op_is_div ? bus.rs_data : bus.rt_data, op_signed)};
    end else if (state == MUL) begin
      prod <= {mul_sum, prod[31:1]};
      cnt  <= cnt + 5'd1;
    end else if (state == DIV) begin
      prod <= {rem_n, quo_n};
      cnt  <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_we_q    <= 1'b0;
      lo_we_q    <= 1'b0;
      hi_wdata_q <= '0;
      lo_wdata_q <= '0;
    end else begin
      busy_q     <= (state_n != IDLE);
      done_q     <= hi_we_n | lo_we_n;
      hi_we_q    <= hi_we_n;
      lo_we_q    <= lo_we_n;
      hi_wdata_q <= hi_d;
      lo_wdata_q <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi_we    = hi_we_q;
  assign bus.lo_we    = lo_we_q;
  assign bus.hi_wdata = hi_wdata_q;
  assign bus.lo_wdata = lo_wdata_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases plus randomized back-to-back ops
// compared against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  localparam logic [2:0] OPC_MULT  = 3'd0;
  localparam logic [2:0] OPC_MULTU = 3'd1;
  localparam logic [2:0] OPC_DIV   = 3'd2;
  localparam logic [2:0] OPC_DIVU  = 3'd3;
  localparam logic [2:0] OPC_MTHI  = 3'd4;
  localparam logic [2:0] OPC_MTLO  = 3'd5;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   wr_count = 0;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.hi_we === 1'b1 || bus.lo_we === 1'b1) wr_count++;
  end

  // Reference results straight from the arithmetic definition of each op.
  function automatic void model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                output int lat, output logic ehwe, output logic elwe,
                                output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    int a, b;
    lat = 34; ehwe = 1'b1; elwe = 1'b1; eh = '0; el = '0;
    case (op)
      OPC_MULT: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        {eh, el} = p; lat = MUL_LAT;
      end
      OPC_MULTU: begin
        p = {32'd0, rs} * {32'd0, rt};
        {eh, el} = p; lat = MUL_LAT;
      end
      OPC_DIV, OPC_DIVU: begin
        if (rt == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = rs; lat = 3;
        end else if (op == OPC_DIVU) begin
          el = rs / rt; eh = rs % rt;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000; eh = 32'd0;
        end else begin
          a = $signed(rs); b = $signed(rt);
          el = a / b; eh = a % b;
        end
      end
      OPC_MTHI: begin eh = rs; elwe = 1'b0; lat = 1; end
      default:  begin el = rs; ehwe = 1'b0; lat = 1; end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       pick_operand = 32'd0;
      1:       pick_operand = 32'h8000_0000;
      2:       pick_operand = 32'hFFFF_FFFF;
      3:       pick_operand = 32'd1;
      default: pick_operand = $urandom;
    endcase
  endfunction

  // Issues one op from an idle cycle and returns what the write port showed in the done cycle.
  task automatic issue_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int lat, output int busy_bad, output logic hwe, output logic lwe,
                          output logic [31:0] hd, output logic [31:0] ld);
    @(negedge clk);
    busy_bad    = (bus.busy !== 1'b0) ? 1 : 0;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.op      = 3'($urandom_range(0, 5));
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
    lat = -1; hwe = 1'b0; lwe = 1'b0; hd = '0; ld = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) begin
        lat = c; hwe = bus.hi_we; lwe = bus.lo_we; hd = bus.hi_wdata; ld = bus.lo_wdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.hi_we, bus.lo_we} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus.busy, bus.done, bus.hi_we, bus.lo_we});
    end
    checks++;
    if ({bus.hi_wdata, bus.lo_wdata} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_wdata: got %h expected 0", {bus.hi_wdata, bus.lo_wdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[7];
    int lat, bb;
    logic hwe, lwe;
    logic [31:0] hd, ld;
    v[0] = '{OPC_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
    v[1] = '{OPC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
    v[2] = '{OPC_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    v[3] = '{OPC_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 3};
    v[4] = '{OPC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
    v[5] = '{OPC_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         MUL_LAT};
    v[6] = '{OPC_DIV,   32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 3};
    foreach (v[i]) begin
      issue_op(v[i].op, v[i].rs, v[i].rt, lat, bb, hwe, lwe, hd, ld);
      checks++;
      if (lat != v[i].lat) begin
        errors++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
      end
      checks++;
      if ({hwe, lwe} !== 2'b11) begin
        errors++; $display("[TB] FAIL directed%0d_we: got %b expected 11", i, {hwe, lwe});
      end
      checks++;
      if (hd !== v[i].hi) begin
        errors++; $display("[TB] FAIL directed%0d_hi: got %h expected %h", i, hd, v[i].hi);
      end
      checks++;
      if (ld !== v[i].lo) begin
        errors++; $display("[TB] FAIL directed%0d_lo: got %h expected %h", i, ld, v[i].lo);
      end
      checks++;
      if (bb != 0) begin
        errors++; $display("[TB] FAIL directed%0d_busy: got %0d bad cycles expected 0", i, bb);
      end
      checks++;
      if ($isunknown({hd, ld, hwe, lwe})) begin
        errors++; $display("[TB] FAIL directed%0d_xcheck: got %h expected no X", i, {hd, ld});
      end
    end
  endtask

  task automatic test_reserved_op();
    int w0;
    #1 w0 = wr_count;
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 3'(k);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
          errors++; $display("[TB] FAIL reserved_op%0d: got busy/done %b expected 00", k, {bus.busy, bus.done});
        end
      end
    end
    #1;
    checks++;
    if (wr_count != w0) begin
      errors++; $display("[TB] FAIL reserved_write: got %0d writes expected %0d", wr_count, w0);
    end
  endtask

  task automatic test_busy_start_and_flush();
    int w0;
    #1 w0 = wr_count;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OPC_DIVU;
    bus.rs_data = $urandom;
    bus.rt_data = $urandom | 32'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus.start = 1'b1; bus.op = OPC_MTHI; bus.rs_data = 32'hDEAD_0000;
      end
      if (c == 6) bus.start = 1'b0;
      if (c == 10) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++; $display("[TB] FAIL busy_before_flush: got %b expected 1", bus.busy);
        end
        bus.flush = 1'b1;
      end
      if (c == 11) begin
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++; $display("[TB] FAIL flush_busy: got %b expected 0", bus.busy);
        end
        #1;
        checks++;
        if (wr_count != w0) begin
          errors++; $display("[TB] FAIL flush_write: got %0d writes expected %0d", wr_count, w0);
        end
        bus.start = 1'b1; bus.op = OPC_MTLO; bus.rs_data = 32'h0000_1234;
      end
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.hi_we, bus.lo_we} !== 3'b101 || bus.lo_wdata !== 32'h0000_1234) begin
      errors++;
      $display("[TB] FAIL mtlo_after_flush: got done/hi_we/lo_we %b data %h expected 101 data 00001234",
               {bus.done, bus.hi_we, bus.lo_we}, bus.lo_wdata);
    end
  endtask

  task automatic test_reset_mid_op();
    int w0, lat, bb;
    logic hwe, lwe;
    logic [31:0] hd, ld, mthi_val;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OPC_MULT; bus.rs_data = $urandom; bus.rt_data = $urandom;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #1 w0 = wr_count;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata} !== 68'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op: got %b %h %h expected all zero",
               {bus.busy, bus.done, bus.hi_we, bus.lo_we}, bus.hi_wdata, bus.lo_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (wr_count != w0) begin
      errors++; $display("[TB] FAIL reset_abort_write: got %0d writes expected %0d", wr_count, w0);
    end
    mthi_val = $urandom;
    issue_op(OPC_MTHI, mthi_val, $urandom, lat, bb, hwe, lwe, hd, ld);
    checks++;
    if (lat != 1 || {hwe, lwe} !== 2'b10 || hd !== mthi_val || bb != 0) begin
      errors++;
      $display("[TB] FAIL mthi_after_reset: got lat %0d we %b hi %h busy_bad %0d expected lat 1 we 10 hi %h busy_bad 0",
               lat, {hwe, lwe}, hd, bb, mthi_val);
    end
  endtask

  task automatic test_random_back_to_back();
    int lat, bb, elat;
    logic hwe, lwe, ehwe, elwe;
    logic [31:0] hd, ld, eh, el, rs, rt;
    logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 5));
      rs = pick_operand();
      rt = pick_operand();
      model(op, rs, rt, elat, ehwe, elwe, eh, el);
      issue_op(op, rs, rt, lat, bb, hwe, lwe, hd, ld);
      checks++;
      if (lat != elat) begin
        errors++; $display("[TB] FAIL rand%0d_latency op%0d: got %0d expected %0d", n, op, lat, elat);
      end
      checks++;
      if ({hwe, lwe} !== {ehwe, elwe}) begin
        errors++; $display("[TB] FAIL rand%0d_we op%0d: got %b expected %b", n, op, {hwe, lwe}, {ehwe, elwe});
      end
      if (ehwe) begin
        checks++;
        if (hd !== eh) begin
          errors++; $display("[TB] FAIL rand%0d_hi op%0d rs %h rt %h: got %h expected %h", n, op, rs, rt, hd, eh);
        end
      end
      if (elwe) begin
        checks++;
        if (ld !== el) begin
          errors++; $display("[TB] FAIL rand%0d_lo op%0d rs %h rt %h: got %h expected %h", n, op, rs, rt, ld, el);
        end
      end
      checks++;
      if (bb != 0) begin
        errors++; $display("[TB] FAIL rand%0d_busy op%0d: got %0d bad cycles expected 0", n, op, bb);
      end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.op      = 3'd0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    rst         = 1'b1;
    test_reset();
    test_directed();
    test_reserved_op();
    test_busy_start_and_flush();
    test_reset_mid_op();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
